// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial scheduler.
//   STATE_W        width of the scheduler state encoding
//   sched_state_t  scheduler FSM states; encodings are visible on the
//                  sched_state debug port, so they are fixed explicitly.
package factorial_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } sched_state_t;

endpackage

// File: rtl/factorial_top.sv
// Iterative factorial core shared by the scheduler.
// Ports:
//   clk     clock, rising edge
//   go      one-cycle start pulse; loads n and clears done
//   n       operand, sampled on go
//   done    level; high once the result is final, stays high until next go
//   result  n! truncated to SIZE bits
// The core has no reset: the first go pulse initialises all of its state.
module factorial_top #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            go,
  input  logic [SIZE-1:0] n,
  output logic            done,
  output logic [SIZE-1:0] result
);

  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] cnt;

  // One multiply per cycle, counting the operand down to 1.
  // n=0 and n=1 finish immediately with acc=1.
  always_ff @(posedge clk) begin
    if (go) begin
      acc  <= SIZE'(1);
      cnt  <= n;
      done <= 1'b0;
    end else if (!done) begin
      if (cnt <= SIZE'(1)) begin
        done <= 1'b1;
      end else begin
        acc <= acc * cnt;
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Ports:
//   req     request vector, one bit per requester
//   ptr     highest-priority index; search runs ptr, ptr+1, ... cyclically
//   gnt     one-hot grant (all zero when no request)
//   gnt_id  index of the granted requester (0 when no request)
//   any     at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk the requesters starting at ptr; the first set bit wins.
  // One extra bit on the sum lets the wrap work for non-power-of-two NUM_REQ.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(off);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      idx = sum[ID_W-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/factorial_sched.sv
// Round-robin scheduler sharing one factorial_top core among NUM_REQ
// requesters.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_n          per-requester operand handshake (req_n packed SIZE per id)
//   req_ready                one-hot accept, only ever high in IDLE
//   rsp_valid/rsp_id/
//   rsp_result/rsp_ready     tagged result handshake
//   core_go/core_n           drive the shared core; core_n held from ISSUE to WAIT_DONE
//   core_done/core_result    from the shared core
//   sched_state              FSM encoding for debug
//   stat_jobs/stat_busy      present only with FACTORIAL_SCHED_STATS_EN:
//                            completed responses and non-IDLE cycles, saturating
// Configuration macro: FACTORIAL_SCHED_STATS_EN
module factorial_sched
  import factorial_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*SIZE-1:0] req_n,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [SIZE-1:0]         rsp_result,
  input  logic                    rsp_ready,
  output logic                    core_go,
  output logic [SIZE-1:0]         core_n,
  input  logic                    core_done,
  input  logic [SIZE-1:0]         core_result,
  output logic [STATE_W-1:0]      sched_state
`ifdef FACTORIAL_SCHED_STATS_EN
  ,
  output logic [15:0]             stat_jobs,
  output logic [31:0]             stat_busy
`endif
);

  sched_state_t state, state_next;

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               any_req;
  logic [SIZE-1:0]    sel_n;

  logic take;      // operand accepted this cycle
  logic capture;   // core result captured this cycle
  logic rsp_done;  // response handshake completes this cycle

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any_req)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_n = req_n[i*SIZE +: SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    core_go    = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (any_req) begin
          take       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        core_go    = 1'b1;
        state_next = WAIT_CLR;
      end
      // The core has no reset and its done is a level, so a done left over
      // from an earlier (possibly aborted) job must be seen low first.
      WAIT_CLR: begin
        if (!core_done) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (core_done) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      core_n     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (take) begin
        core_n <= sel_n;
        rsp_id <= gnt_id;
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
      if (capture) begin
        rsp_result <= core_result;
        rsp_valid  <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign sched_state = state;

`ifdef FACTORIAL_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_jobs <= '0;
      stat_busy <= '0;
    end else begin
      if (rsp_done && (stat_jobs != '1)) begin
        stat_jobs <= stat_jobs + 1'b1;
      end
      if ((state != IDLE) && (stat_busy != '1)) begin
        stat_busy <= stat_busy + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_factorial_sched.sv
// Self-checking bench for factorial_sched driving a real factorial_top core.
// Build with FACTORIAL_SCHED_STATS_EN defined to exercise the counters.
module tb_factorial_sched;

  localparam int SIZE    = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ*SIZE-1:0] req_n = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [SIZE-1:0]         rsp_result;
  logic                    rsp_ready = 1'b1;
  logic                    core_go;
  logic [SIZE-1:0]         core_n;
  logic                    core_done;
  logic [SIZE-1:0]         core_result;
  logic [2:0]              sched_state;
`ifdef FACTORIAL_SCHED_STATS_EN
  logic [15:0]             stat_jobs;
  logic [31:0]             stat_busy;
`endif

  always #5 clk = ~clk;

  factorial_sched #(.SIZE(SIZE), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_n       (req_n),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_ready   (rsp_ready),
    .core_go     (core_go),
    .core_n      (core_n),
    .core_done   (core_done),
    .core_result (core_result),
    .sched_state (sched_state)
`ifdef FACTORIAL_SCHED_STATS_EN
    ,
    .stat_jobs   (stat_jobs),
    .stat_busy   (stat_busy)
`endif
  );

  factorial_top #(.SIZE(SIZE)) u_core (
    .clk    (clk),
    .go     (core_go),
    .n      (core_n),
    .done   (core_done),
    .result (core_result)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int go_cnt = 0;
  int rdy_cnt = 0;
  int busy_cnt = 0;
  int model_ptr = 0;
  logic [SIZE-1:0] exp_n [NUM_REQ];

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (core_go) go_cnt++;
    if (req_ready != '0) rdy_cnt++;
    if (rst) busy_cnt = 0;
    else if (sched_state != 3'd0) busy_cnt++;
  end

  // Reference: n! truncated to SIZE bits.
  function automatic logic [SIZE-1:0] fact(input logic [SIZE-1:0] n);
    logic [SIZE-1:0] f;
    f = 1;
    for (int k = 2; k <= int'(n); k++) f = f * SIZE'(k);
    return f;
  endfunction

  // Reference: first valid requester at or after ptr, cyclically.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
    int i;
    for (int o = 0; o < NUM_REQ; o++) begin
      i = (ptr + o) % NUM_REQ;
      if (((v >> i) & NUM_REQ'(1)) != '0) return i;
    end
    return -1;
  endfunction

  task automatic set_n(input int id, input logic [SIZE-1:0] n);
    req_n[id*SIZE +: SIZE] = n;
    exp_n[id] = n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
  endtask

  // Returns the observed grant and leaves the bench just after the accept edge.
  task automatic wait_grant(output logic [NUM_REQ-1:0] g, output bit to);
    g = '0;
    to = 1'b1;
    #1;
    for (int c = 0; c < 2000; c++) begin
      if (req_ready != '0) begin
        g = req_ready;
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (!to) begin
      @(posedge clk); #1;
    end
  endtask

  // Returns the first observed response; passes the handshake edge if rsp_ready.
  task automatic wait_rsp(output logic [ID_W-1:0] id, output logic [SIZE-1:0] r, output bit to);
    id = '0;
    r = '0;
    to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        id = rsp_id;
        r = rsp_result;
        to = 1'b0;
        break;
      end
    end
    if (!to && rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sched_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", sched_state); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_id !== '0) begin failures++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
    checks++; if (rsp_result !== '0) begin failures++; $display("FAIL reset_rsp_result got=%0d want=0", rsp_result); end
    checks++; if (core_go !== 1'b0) begin failures++; $display("FAIL reset_core_go got=%b want=0", core_go); end
    checks++; if (core_n !== '0) begin failures++; $display("FAIL reset_core_n got=%0d want=0", core_n); end
    $display("test_reset: state=%0d rsp_valid=%b core_n=%0d", sched_state, rsp_valid, core_n);
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] g;
    logic [ID_W-1:0] id;
    logic [SIZE-1:0] r;
    bit to;
    int e, go0, rdy0;
    go0 = go_cnt;
    rdy0 = rdy_cnt;
    set_n(0, 8'd5);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    e = pick(req_valid, model_ptr);
    wait_grant(g, to);
    req_valid = '0;
    checks++; if (to || g !== (NUM_REQ'(1) << e)) begin failures++; $display("FAIL single_grant got=%b want=%b", g, NUM_REQ'(1) << e); end
    model_ptr = (e + 1) % NUM_REQ;
    wait_rsp(id, r, to);
    checks++; if (to || id !== ID_W'(e)) begin failures++; $display("FAIL single_rsp_id got=%0d want=%0d", id, e); end
    checks++; if (to || r !== fact(exp_n[e])) begin failures++; $display("FAIL single_rsp_result got=%0d want=%0d", r, fact(exp_n[e])); end
    checks++; if (go_cnt - go0 != 1) begin failures++; $display("FAIL single_go_pulses got=%0d want=1", go_cnt - go0); end
    checks++; if (rdy_cnt - rdy0 != 1) begin failures++; $display("FAIL single_ready_pulses got=%0d want=1", rdy_cnt - rdy0); end
    $display("test_single: id=%0d n=%0d result=%0d", id, exp_n[0], r);
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] g;
    logic [ID_W-1:0] id;
    logic [SIZE-1:0] r;
    bit to;
    int e, last;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_n(i, SIZE'(i + 1));
    req_valid = 4'b1111;
    last = 0;
    for (int j = 0; j < 5; j++) begin
      e = pick(req_valid, model_ptr);
      wait_grant(g, to);
      if (j == 4) req_valid = '0;
      checks++; if (to || g !== (NUM_REQ'(1) << e)) begin failures++; $display("FAIL rr_grant%0d got=%b want=%b", j, g, NUM_REQ'(1) << e); end
      if (j == 4) begin
        checks++; if (g !== 4'b0001) begin failures++; $display("FAIL rr_wrap got=%b want=0001", g); end
      end
      if (j > 0) begin
        checks++; if (cycle - last < 5) begin failures++; $display("FAIL rr_spacing got=%0d want>=5", cycle - last); end
      end
      last = cycle;
      model_ptr = (e + 1) % NUM_REQ;
      wait_rsp(id, r, to);
      checks++; if (to || id !== ID_W'(e) || r !== fact(exp_n[e])) begin failures++; $display("FAIL rr_rsp%0d got=%0d/%0d want=%0d/%0d", j, id, r, e, fact(exp_n[e])); end
      $display("test_round_robin: grant=%b id=%0d result=%0d", g, id, r);
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] g;
    logic [ID_W-1:0] id;
    logic [SIZE-1:0] r;
    bit to;
    int e, go0;
    rsp_ready = 1'b0;
    set_n(2, 8'd4);
    req_valid = 4'b0100;
    e = pick(req_valid, model_ptr);
    wait_grant(g, to);
    checks++; if (to || g !== (NUM_REQ'(1) << e)) begin failures++; $display("FAIL bp_grant got=%b want=%b", g, NUM_REQ'(1) << e); end
    model_ptr = (e + 1) % NUM_REQ;
    req_valid = 4'b1111;
    wait_rsp(id, r, to);
    checks++; if (to || id !== ID_W'(e) || r !== fact(exp_n[e])) begin failures++; $display("FAIL bp_rsp got=%0d/%0d want=%0d/%0d", id, r, e, fact(exp_n[e])); end
    go0 = go_cnt;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(e) || rsp_result !== fact(exp_n[e])) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%0d/%0d want=1/%0d/%0d", c, rsp_valid, rsp_id, rsp_result, e, fact(exp_n[e]));
      end
      checks++; if (req_ready !== '0 || core_go !== 1'b0) begin failures++; $display("FAIL bp_quiet%0d got=%b/%b want=0/0", c, req_ready, core_go); end
    end
    checks++; if (go_cnt != go0) begin failures++; $display("FAIL bp_go_count got=%0d want=%0d", go_cnt, go0); end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || sched_state !== 3'd0) begin failures++; $display("FAIL bp_release got=%b/%0d want=0/0", rsp_valid, sched_state); end
    $display("test_backpressure: id=%0d result=%0d held 10 cycles", id, r);
  endtask

  task automatic test_reset_mid_job();
    logic [NUM_REQ-1:0] g;
    logic [ID_W-1:0] id;
    logic [SIZE-1:0] r;
    bit to;
    bit seen;
    set_n(0, 8'd7);
    req_valid = 4'b0001;
    wait_grant(g, to);
    req_valid = '0;
    checks++; if (to || g !== 4'b0001) begin failures++; $display("FAIL mid_grant got=%b want=0001", g); end
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (sched_state == 3'd3) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL mid_wait_done got=%0d want=3", sched_state); end
    rst = 1'b1;
    #1;
    checks++; if (sched_state !== 3'd0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_result !== '0 || core_go !== 1'b0 || core_n !== '0 || req_ready !== '0) begin
      failures++; $display("FAIL mid_async_reset got=st%0d v%b id%0d r%0d go%b n%0d rdy%b want=all0", sched_state, rsp_valid, rsp_id, rsp_result, core_go, core_n, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_ptr = 0;
    set_n(1, 8'd3);
    req_valid = 4'b0010;
    wait_grant(g, to);
    req_valid = '0;
    checks++; if (to || g !== 4'b0010) begin failures++; $display("FAIL mid_regrant got=%b want=0010", g); end
    model_ptr = 2;
    wait_rsp(id, r, to);
    checks++; if (to || id !== 2'd1 || r !== fact(8'd3)) begin failures++; $display("FAIL mid_rsp got=%0d/%0d want=1/%0d", id, r, fact(8'd3)); end
    $display("test_reset_mid_job: after reset id=%0d result=%0d", id, r);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] pend;
    logic [ID_W-1:0] id;
    logic [SIZE-1:0] r;
    bit to;
    int e;
    pend = '0;
    rsp_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (((pend >> i) & NUM_REQ'(1)) == '0 && $urandom_range(0, 1) == 1) begin
          pend = pend | (NUM_REQ'(1) << i);
          set_n(i, ($urandom_range(0, 11) == 0) ? 8'hFF : SIZE'($urandom_range(0, 9)));
        end
      end
      if (pend == '0) begin
        e = int'($urandom_range(0, NUM_REQ - 1));
        pend = NUM_REQ'(1) << e;
        set_n(e, SIZE'($urandom_range(0, 9)));
      end
      req_valid = pend;
      e = pick(pend, model_ptr);
      wait_grant(g, to);
      pend = pend & ~(NUM_REQ'(1) << e);
      req_valid = pend;
      checks++; if (to || g !== (NUM_REQ'(1) << e)) begin failures++; $display("FAIL rnd_grant%0d got=%b want=%b", j, g, NUM_REQ'(1) << e); end
      model_ptr = (e + 1) % NUM_REQ;
      wait_rsp(id, r, to);
      checks++; if (to || id !== ID_W'(e) || r !== fact(exp_n[e])) begin failures++; $display("FAIL rnd_rsp%0d got=%0d/%0d want=%0d/%0d", j, id, r, e, fact(exp_n[e])); end
      $display("test_random: job=%0d id=%0d n=%0d result=%0d", j, id, exp_n[e], r);
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

`ifdef FACTORIAL_SCHED_STATS_EN
  task automatic test_stats();
    logic [NUM_REQ-1:0] g;
    logic [ID_W-1:0] id;
    logic [SIZE-1:0] r;
    bit to;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      set_n(j, SIZE'(j + 2));
      req_valid = NUM_REQ'(1) << j;
      wait_grant(g, to);
      req_valid = '0;
      wait_rsp(id, r, to);
      checks++; if (to || r !== fact(exp_n[j])) begin failures++; $display("FAIL stats_rsp%0d got=%0d want=%0d", j, r, fact(exp_n[j])); end
    end
    checks++; if (stat_jobs !== 16'd3) begin failures++; $display("FAIL stats_jobs got=%0d want=3", stat_jobs); end
    checks++; if (stat_busy !== 32'(busy_cnt)) begin failures++; $display("FAIL stats_busy got=%0d want=%0d", stat_busy, busy_cnt); end
    $display("test_stats: jobs=%0d busy=%0d", stat_jobs, stat_busy);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_job();
    test_random();
`ifdef FACTORIAL_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
